// File: rtl/axis_weight_mult.sv
`default_nettype none
// ============================================================================
//  Module      : axis_weight_mult
//  Description : Per-channel complex weight stage for the beamforming adder.
//                Multiplies each 16-bit complex sample by a signed complex
//                weight, then rounds half-up and saturates back to 16 bits.
//                Weight updates are deferred to packet boundaries.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_weight_mult #(
  parameter int SDATA_WIDTH   = 128,
  parameter int SSAMPLE_WIDTH = 16,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int WEIGHT_FRAC   = 6,
  parameter int SAMPLES       = SDATA_WIDTH / SSAMPLE_WIDTH
) (
  input  logic                       clock,
  input  logic                       resetn,
  // slave streams
  input  logic [SDATA_WIDTH-1:0]     s_axis_real_tdata,
  input  logic                       s_axis_real_tvalid,
  input  logic                       s_axis_real_tlast,
  output logic                       s_axis_real_tready,
  input  logic [SDATA_WIDTH-1:0]     s_axis_imag_tdata,
  input  logic                       s_axis_imag_tvalid,
  input  logic                       s_axis_imag_tlast,
  output logic                       s_axis_imag_tready,
  // master streams
  output logic [SDATA_WIDTH-1:0]     m_axis_real_tdata,
  output logic                       m_axis_real_tvalid,
  output logic [SDATA_WIDTH/8-1:0]   m_axis_real_tkeep,
  output logic                       m_axis_real_tlast,
  input  logic                       m_axis_real_tready,
  output logic [SDATA_WIDTH-1:0]     m_axis_imag_tdata,
  output logic                       m_axis_imag_tvalid,
  output logic [SDATA_WIDTH/8-1:0]   m_axis_imag_tkeep,
  output logic                       m_axis_imag_tlast,
  input  logic                       m_axis_imag_tready,
  // weight control and status
  input  logic                       weight_wr,
  input  logic [WEIGHT_WIDTH-1:0]    weight_re,
  input  logic [WEIGHT_WIDTH-1:0]    weight_im,
  output logic                       weight_pending,
  output logic                       sat_flag,
  output logic                       tlast_err
);

  localparam int PROD_W = SSAMPLE_WIDTH + WEIGHT_WIDTH;
  localparam int SUM_W  = PROD_W + 1;
  localparam int RND_W  = SUM_W + 1;
  localparam int KEEP_W = SDATA_WIDTH / 8;

  localparam logic signed [RND_W-1:0] c_half = RND_W'(1 << (WEIGHT_FRAC - 1));
  localparam logic signed [RND_W-1:0] c_max  = RND_W'((1 << (SSAMPLE_WIDTH - 1)) - 1);
  localparam logic signed [RND_W-1:0] c_min  = ~c_max;
  localparam logic [WEIGHT_WIDTH-1:0] c_unity_re = WEIGHT_WIDTH'(1 << WEIGHT_FRAC);

  typedef logic signed [SSAMPLE_WIDTH-1:0] sample_t;
  typedef logic signed [WEIGHT_WIDTH-1:0]  weight_t;
  typedef logic signed [PROD_W-1:0]        prod_t;
  typedef logic signed [SUM_W-1:0]         sum_t;

  // Round half up, shift out the weight fraction and clip to the sample range.
  // Returns {clipped, value}.
  function automatic logic [SSAMPLE_WIDTH:0] round_sat(input sum_t v);
    logic signed [RND_W-1:0] rnd;
    logic signed [RND_W-1:0] shr;
    rnd = RND_W'(v) + c_half;
    shr = rnd >>> WEIGHT_FRAC;
    if (shr > c_max) begin
      round_sat = {1'b1, c_max[SSAMPLE_WIDTH-1:0]};
    end else if (shr < c_min) begin
      round_sat = {1'b1, c_min[SSAMPLE_WIDTH-1:0]};
    end else begin
      round_sat = {1'b0, shr[SSAMPLE_WIDTH-1:0]};
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  logic    ce;
  logic    s_ready;
  logic    accept;
  logic    apply;
  logic    ready_en_q,  ready_en_d;
  weight_t act_re_q,    act_re_d;
  weight_t act_im_q,    act_im_d;
  weight_t pend_re_q,   pend_re_d;
  weight_t pend_im_q,   pend_im_d;
  logic    pending_q,   pending_d;
  logic    in_packet_q, in_packet_d;
  logic    tlast_err_q, tlast_err_d;
  logic    sat_q,       sat_d;

  // ---------------------------------------------------------------------------
  // Pipeline: input register, S1 multiply, S2 add/sub, S3 round/saturate
  // ---------------------------------------------------------------------------
  sample_t in_re_q [SAMPLES];
  sample_t in_re_d [SAMPLES];
  sample_t in_im_q [SAMPLES];
  sample_t in_im_d [SAMPLES];
  weight_t in_wre_q, in_wre_d;
  weight_t in_wim_q, in_wim_d;
  logic    in_valid_q, in_valid_d;
  logic    in_last_q,  in_last_d;

  prod_t   ac_q [SAMPLES];
  prod_t   ac_d [SAMPLES];
  prod_t   bd_q [SAMPLES];
  prod_t   bd_d [SAMPLES];
  prod_t   ad_q [SAMPLES];
  prod_t   ad_d [SAMPLES];
  prod_t   bc_q [SAMPLES];
  prod_t   bc_d [SAMPLES];
  logic    s1_valid_q, s1_valid_d;
  logic    s1_last_q,  s1_last_d;

  sum_t    sre_q [SAMPLES];
  sum_t    sre_d [SAMPLES];
  sum_t    sim_q [SAMPLES];
  sum_t    sim_d [SAMPLES];
  logic    s2_valid_q, s2_valid_d;
  logic    s2_last_q,  s2_last_d;

  sample_t out_re_q [SAMPLES];
  sample_t out_re_d [SAMPLES];
  sample_t out_im_q [SAMPLES];
  sample_t out_im_d [SAMPLES];
  logic    s3_valid_q, s3_valid_d;
  logic    s3_last_q,  s3_last_d;

  logic [SSAMPLE_WIDTH:0] w_rs [SAMPLES];
  logic [SSAMPLE_WIDTH:0] w_is [SAMPLES];
  logic [SAMPLES-1:0]     w_lane_sat;

  // Handshake, weight hand-over at packet boundaries, and status flags
  always_comb begin
    ce          = !s3_valid_q || (m_axis_real_tready && m_axis_imag_tready);
    s_ready     = ce && ready_en_q;
    accept      = s_axis_real_tvalid && s_axis_imag_tvalid && s_ready;
    // The tlast beat itself still uses the old weight; the swap lands behind it.
    apply       = pending_q && ((!in_packet_q && !accept) ||
                                (accept && s_axis_real_tlast));
    ready_en_d  = 1'b1;
    act_re_d    = act_re_q;
    act_im_d    = act_im_q;
    pend_re_d   = pend_re_q;
    pend_im_d   = pend_im_q;
    pending_d   = pending_q;
    in_packet_d = in_packet_q;
    tlast_err_d = tlast_err_q;
    sat_d       = ce && s2_valid_q && (|w_lane_sat);

    if (apply) begin
      act_re_d  = pend_re_q;
      act_im_d  = pend_im_q;
      pending_d = 1'b0;
    end
    // A write coinciding with an apply remains pending for the next boundary.
    if (weight_wr) begin
      pend_re_d = weight_re;
      pend_im_d = weight_im;
      pending_d = 1'b1;
    end
    if (accept) begin
      in_packet_d = !s_axis_real_tlast;
      if (s_axis_real_tlast != s_axis_imag_tlast) begin
        tlast_err_d = 1'b1;
      end
    end
  end

  // Per-lane datapath; every stage loads on ce and holds otherwise
  always_comb begin
    in_re_d    = in_re_q;
    in_im_d    = in_im_q;
    in_wre_d   = in_wre_q;
    in_wim_d   = in_wim_q;
    in_valid_d = in_valid_q;
    in_last_d  = in_last_q;
    ac_d       = ac_q;
    bd_d       = bd_q;
    ad_d       = ad_q;
    bc_d       = bc_q;
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    sre_d      = sre_q;
    sim_d      = sim_q;
    s2_valid_d = s2_valid_q;
    s2_last_d  = s2_last_q;
    out_re_d   = out_re_q;
    out_im_d   = out_im_q;
    s3_valid_d = s3_valid_q;
    s3_last_d  = s3_last_q;
    w_lane_sat = '0;

    for (int l = 0; l < SAMPLES; l++) begin
      w_rs[l]       = round_sat(sre_q[l]);
      w_is[l]       = round_sat(sim_q[l]);
      w_lane_sat[l] = w_rs[l][SSAMPLE_WIDTH] | w_is[l][SSAMPLE_WIDTH];
    end

    if (ce) begin
      // Input register snapshots the active weight with the beat.
      in_valid_d = accept;
      in_last_d  = s_axis_real_tlast;
      if (accept) begin
        in_wre_d = act_re_q;
        in_wim_d = act_im_q;
        for (int l = 0; l < SAMPLES; l++) begin
          in_re_d[l] = s_axis_real_tdata[l*SSAMPLE_WIDTH +: SSAMPLE_WIDTH];
          in_im_d[l] = s_axis_imag_tdata[l*SSAMPLE_WIDTH +: SSAMPLE_WIDTH];
        end
      end
      s1_valid_d = in_valid_q;
      s1_last_d  = in_last_q;
      s2_valid_d = s1_valid_q;
      s2_last_d  = s1_last_q;
      s3_valid_d = s2_valid_q;
      s3_last_d  = s2_last_q;
      for (int l = 0; l < SAMPLES; l++) begin
        ac_d[l]     = PROD_W'(in_re_q[l]) * PROD_W'(in_wre_q);
        bd_d[l]     = PROD_W'(in_im_q[l]) * PROD_W'(in_wim_q);
        ad_d[l]     = PROD_W'(in_re_q[l]) * PROD_W'(in_wim_q);
        bc_d[l]     = PROD_W'(in_im_q[l]) * PROD_W'(in_wre_q);
        sre_d[l]    = SUM_W'(ac_q[l]) - SUM_W'(bd_q[l]);
        sim_d[l]    = SUM_W'(ad_q[l]) + SUM_W'(bc_q[l]);
        out_re_d[l] = w_rs[l][SSAMPLE_WIDTH-1:0];
        out_im_d[l] = w_is[l][SSAMPLE_WIDTH-1:0];
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ready_en_q  <= 1'b0;
      act_re_q    <= c_unity_re;
      act_im_q    <= '0;
      pend_re_q   <= '0;
      pend_im_q   <= '0;
      pending_q   <= 1'b0;
      in_packet_q <= 1'b0;
      tlast_err_q <= 1'b0;
      sat_q       <= 1'b0;
      in_wre_q    <= '0;
      in_wim_q    <= '0;
      in_valid_q  <= 1'b0;
      in_last_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s3_valid_q  <= 1'b0;
      s3_last_q   <= 1'b0;
      for (int l = 0; l < SAMPLES; l++) begin
        in_re_q[l]  <= '0;
        in_im_q[l]  <= '0;
        ac_q[l]     <= '0;
        bd_q[l]     <= '0;
        ad_q[l]     <= '0;
        bc_q[l]     <= '0;
        sre_q[l]    <= '0;
        sim_q[l]    <= '0;
        out_re_q[l] <= '0;
        out_im_q[l] <= '0;
      end
    end else begin
      ready_en_q  <= ready_en_d;
      act_re_q    <= act_re_d;
      act_im_q    <= act_im_d;
      pend_re_q   <= pend_re_d;
      pend_im_q   <= pend_im_d;
      pending_q   <= pending_d;
      in_packet_q <= in_packet_d;
      tlast_err_q <= tlast_err_d;
      sat_q       <= sat_d;
      in_wre_q    <= in_wre_d;
      in_wim_q    <= in_wim_d;
      in_valid_q  <= in_valid_d;
      in_last_q   <= in_last_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s2_valid_q  <= s2_valid_d;
      s2_last_q   <= s2_last_d;
      s3_valid_q  <= s3_valid_d;
      s3_last_q   <= s3_last_d;
      in_re_q     <= in_re_d;
      in_im_q     <= in_im_d;
      ac_q        <= ac_d;
      bd_q        <= bd_d;
      ad_q        <= ad_d;
      bc_q        <= bc_d;
      sre_q       <= sre_d;
      sim_q       <= sim_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  // Output packing: sample i at bits [16i +: 16]
  genvar g;
  generate
    for (g = 0; g < SAMPLES; g++) begin : g_pack
      assign m_axis_real_tdata[g*SSAMPLE_WIDTH +: SSAMPLE_WIDTH] = out_re_q[g];
      assign m_axis_imag_tdata[g*SSAMPLE_WIDTH +: SSAMPLE_WIDTH] = out_im_q[g];
    end
  endgenerate

  assign s_axis_real_tready = s_ready;
  assign s_axis_imag_tready = s_ready;
  assign m_axis_real_tvalid = s3_valid_q;
  assign m_axis_imag_tvalid = s3_valid_q;
  assign m_axis_real_tlast  = s3_last_q;
  assign m_axis_imag_tlast  = s3_last_q;
  assign m_axis_real_tkeep  = {KEEP_W{s3_valid_q}};
  assign m_axis_imag_tkeep  = {KEEP_W{s3_valid_q}};
  assign weight_pending     = pending_q;
  assign sat_flag           = sat_q;
  assign tlast_err          = tlast_err_q;

endmodule
`default_nettype wire
